picorv32_trace_packer: RTL and testbench
========================================

# picorv32_trace_packer

Consumes the per-retired-instruction trace stream (`trace_valid` / 36-bit `trace_data`) produced by the `picorv32_axi` core in the simulation wrapper. It buffers the stream in a small FIFO and packs consecutive trace words into fixed-width packets on a ready/valid output, for hand-off to a switchboard queue bridge. Trace words arrive at core rate with no backpressure, so the block absorbs bursts, drops on overflow, and counts the drops. A partially filled packet is flushed after a programmable idle time.

## Interface
- `DEPTH`, 16: FIFO depth in 36-bit entries; power of two, ≥2.
- `PKT_WORDS`, 4: trace words per packet; 1..127.
- `FLUSH_CYCLES`, 64: idle cycles before a partial packet is sent; 0 disables the timeout.
- `clk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset. This is decided: one clock, async active-low reset.
- `trace_valid` in 1: a trace word is present this cycle. There is no ready; the source never stalls.
- `trace_data` in 36: trace word, opaque to this block.
- `out_valid` out 1: a packet is available.
- `out_ready` in 1: the consumer accepts the packet.
- `out_data` out 8+36·PKT_WORDS: the packet.
- `drop_count` out 16: saturating count of words dropped on overflow.

## Operation
- Packet layout:
  - `out_data[6:0]` = word count.
  - `out_data[7]` = drop flag.
  - Word i occupies `out_data[8+36*i +: 36]`. Word 0 is the oldest.
  - Unused word slots are zero.
- FIFO write:
  - When `trace_valid && !full`, the word is written.
  - When `trace_valid && full`, the word is discarded. `drop_count` increments and saturates at 0xFFFF. The sticky `drop_flag` is set.
  - Pointers are log2(DEPTH)+1 bits. Full means MSBs differ and the low bits are equal.
- Packer FSM has two states:
  - FILL:
    - If the FIFO is not empty and `fill < PKT_WORDS`, pop one word per cycle into slot `fill`, then `fill++`.
    - Go to SEND when `fill == PKT_WORDS`.
    - Also go to SEND when `fill > 0`, `FLUSH_CYCLES != 0`, and `idle_cnt == FLUSH_CYCLES`.
  - SEND:
    - `out_valid = 1`. `out_data` is registered and held stable.
    - No pops occur.
    - On `out_ready`, clear `fill` and the slot contents and return to FILL.
- `idle_cnt`:
  - Increments in FILL when `fill > 0` and no pop occurs.
  - Clears on a pop, on entry to SEND, and when `fill == 0`.
- Drop flag:
  - The header bit is sampled from `drop_flag` on the FILL→SEND transition.
  - `drop_flag` clears on the SEND handshake, unless a new drop occurs in that same cycle, in which case it stays set.
- FIFO writes continue while in SEND. Overflow in SEND follows the same drop rules.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `drop_count` = 0.
  - FIFO empty, `fill` = 0, `idle_cnt` = 0, `drop_flag` = 0.
  - State = FILL.
- Minimum latency: a word with `trace_valid` in cycle t is in the FIFO at t+1 and popped at the end of t+1. With `PKT_WORDS`=1, `out_valid` is high in t+2.
- Steady state: one pop per cycle, so a full packet is ready `PKT_WORDS` cycles after its first pop.
- Handshake: the transfer occurs on the edge where `out_valid && out_ready`. `out_valid` never drops without a handshake. `out_ready` may be high before `out_valid`.
- Throughput:
  - The next packet fills starting the cycle after the handshake.
  - Sustained rate is `PKT_WORDS` words per `PKT_WORDS`+1 cycles.
  - Overflow is possible only when the input is back-to-back or `out_ready` stalls.
- Reset mid-packet: the partial packet and the FIFO contents are discarded, with no output.

## Structure
- Package `picorv32_trace_pkg`:
  - Header bit positions `HDR_CNT_LSB`/`HDR_CNT_MSB`/`HDR_DROP`.
  - `TRACE_W` = 36.
  - FSM state enum `{ST_FILL, ST_SEND}`.
- Sub-module `picorv32_trace_fifo`, parameterized by width and depth:
  - Ports `push`, `din`, `full`, `pop`, `dout`, `empty`.
  - Registered storage; `dout` is valid whenever `!empty`.
- The top level holds the FSM, slot registers, `idle_cnt`, and drop logic.

## Test plan
- **Single full packet.** `PKT_WORDS`=4, `out_ready`=1; push 0x1_00000001 .. 0x1_00000004 on consecutive cycles.
  - One packet: header 0x04, words in order, `out_valid` high for 1 cycle.
- **Timeout flush.** `FLUSH_CYCLES`=8; push 2 words, then idle.
  - Packet with header 0x02 and slots 2–3 zero.
  - `out_valid` rises exactly 8 idle cycles after the last pop.
- **Backpressure and overflow.** `DEPTH`=16, `out_ready`=0; push 40 words back-to-back.
  - FIFO holds 16, one packet holds 4, and `drop_count` = 20.
  - Release `out_ready`: the first packet has the drop bit set (header 0x84), and later packets have 0x04.
- **Saturation.** Force `drop_count` to 0xFFFE, then overflow by 5 words.
  - `drop_count` = 0xFFFF.
- **Drop during handshake.** With a packet in SEND and the FIFO full, push a word in the same cycle `out_ready` is asserted.
  - The next packet's header has bit 7 = 1.
- **Reset mid-fill.** Push 3 words, assert `resetn`=0 for 1 cycle, then push 4 new words.
  - Only the 4 new words appear; `drop_count` = 0.

Source files
------------

// File: rtl/picorv32_trace_pkg.sv
// Shared definitions for the picorv32 trace packer.
// Holds the trace word width, the packet header bit positions and the
// packer FSM state type.
package picorv32_trace_pkg;

   localparam int TRACE_W     = 36;
   localparam int HDR_CNT_LSB = 0;
   localparam int HDR_CNT_MSB = 6;
   localparam int HDR_DROP    = 7;
   localparam int HDR_W       = 8;

   typedef enum logic {
      ST_FILL,
      ST_SEND
   } state_t;

endpackage

// File: rtl/picorv32_trace_packer_if.sv
// Trace-in / packet-out bundle for the picorv32 trace packer.
//   trace_valid, trace_data : retired-instruction trace stream (no ready)
//   out_valid, out_ready    : packet handshake
//   out_data                : header byte followed by PKT_WORDS trace slots
//   drop_count              : saturating overflow drop counter
// master = trace source / packet consumer, slave = the packer.
interface picorv32_trace_packer_if #(
   parameter int PKT_WORDS = 4
);
   localparam int PKT_W = picorv32_trace_pkg::HDR_W + picorv32_trace_pkg::TRACE_W * PKT_WORDS;

   logic                                  trace_valid;
   logic [picorv32_trace_pkg::TRACE_W-1:0] trace_data;
   logic                                  out_valid;
   logic                                  out_ready;
   logic [PKT_W-1:0]                      out_data;
   logic [15:0]                           drop_count;

   modport master (
      output trace_valid, trace_data, out_ready,
      input  out_valid, out_data, drop_count
   );

   modport slave (
      input  trace_valid, trace_data, out_ready,
      output out_valid, out_data, drop_count
   );

endinterface

// File: rtl/picorv32_trace_fifo.sv
// Synchronous FIFO with registered storage.
//   push/din : write request; ignored while full
//   pop      : read request; ignored while empty
//   dout     : head entry, valid whenever !empty
//   full/empty derived from (log2(DEPTH)+1)-bit pointers
module picorv32_trace_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   // Extra MSB distinguishes a wrapped writer (full) from equal pointers (empty).
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/picorv32_trace_packer.sv
// Buffers the picorv32 per-instruction trace stream and packs it into
// fixed-size packets on a ready/valid output.
//   clk, resetn : single clock, asynchronous active-low reset
//   bus (slave) : trace_valid/trace_data in, out_valid/out_ready/out_data
//                 packet handshake, drop_count overflow counter
// Packets carry a word count, a drop flag and PKT_WORDS slots (oldest in
// slot 0, unused slots zero). A partial packet is sent after FLUSH_CYCLES
// idle cycles (0 disables the timeout).
module picorv32_trace_packer
   import picorv32_trace_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int PKT_WORDS    = 4,
   parameter int FLUSH_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    resetn,
   picorv32_trace_packer_if.slave  bus
);

   localparam int IDLE_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

   state_t               state;
   state_t               state_nxt;
   logic [6:0]           fill;
   logic [6:0]           fill_nxt;
   logic [IDLE_W-1:0]    idle_cnt;
   logic [TRACE_W-1:0]   slot [PKT_WORDS];
   logic                 hdr_drop;
   logic                 drop_flag;
   logic                 drop_flag_nxt;
   logic [15:0]          drop_cnt;
   logic                 pop;
   logic                 timeout;
   logic                 handshake;
   logic                 drop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [TRACE_W-1:0]   fifo_dout;

   picorv32_trace_fifo #(
      .WIDTH (TRACE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (bus.trace_valid),
      .din    (bus.trace_data),
      .full   (fifo_full),
      .pop    (pop),
      .dout   (fifo_dout),
      .empty  (fifo_empty)
   );

   assign drop = bus.trace_valid && fifo_full;

   // A drop coinciding with the handshake is not reported by the departing
   // packet, so it keeps the flag set for the next one.
   assign drop_flag_nxt = handshake ? drop : (drop_flag || drop);

   always_comb begin
      state_nxt = state;
      fill_nxt  = fill;
      pop       = 1'b0;
      timeout   = 1'b0;
      handshake = 1'b0;
      case (state)
         ST_FILL: begin
            pop = !fifo_empty && (fill < 7'(PKT_WORDS));
            if (pop)
               fill_nxt = fill + 1'b1;
            timeout = (FLUSH_CYCLES != 0) && (fill != '0) &&
                      (idle_cnt == IDLE_W'(FLUSH_CYCLES));
            // Leaving on the completing pop lets a full packet present the
            // cycle after its last word is taken.
            if ((fill_nxt == 7'(PKT_WORDS)) || timeout)
               state_nxt = ST_SEND;
         end
         ST_SEND: begin
            handshake = bus.out_ready;
            if (handshake) begin
               state_nxt = ST_FILL;
               fill_nxt  = '0;
            end
         end
         default: state_nxt = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_FILL;
         fill      <= '0;
         idle_cnt  <= '0;
         hdr_drop  <= 1'b0;
         drop_flag <= 1'b0;
         drop_cnt  <= '0;
         for (int i = 0; i < PKT_WORDS; i++)
            slot[i] <= '0;
      end else begin
         state     <= state_nxt;
         fill      <= fill_nxt;
         drop_flag <= drop_flag_nxt;

         for (int i = 0; i < PKT_WORDS; i++) begin
            if (handshake)
               slot[i] <= '0;
            else if (pop && (fill == 7'(i)))
               slot[i] <= fifo_dout;
         end

         if ((state != ST_FILL) || (fill == '0) || pop || (state_nxt == ST_SEND))
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + 1'b1;

         // Header drop bit is loaded on entry to SEND and keeps absorbing
         // drops while the packet waits, so words lost during a stall are
         // reported by the packet that is eventually handed off.
         if ((state == ST_FILL) && (state_nxt == ST_SEND))
            hdr_drop <= drop_flag;
         else if (handshake)
            hdr_drop <= 1'b0;
         else if (state == ST_SEND)
            hdr_drop <= drop_flag_nxt;

         if (drop && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

   assign bus.out_valid  = (state == ST_SEND);
   assign bus.drop_count = drop_cnt;

   always_comb begin
      bus.out_data = '0;
      bus.out_data[HDR_CNT_MSB:HDR_CNT_LSB] = fill;
      bus.out_data[HDR_DROP]                = hdr_drop;
      for (int i = 0; i < PKT_WORDS; i++)
         bus.out_data[HDR_W + TRACE_W*i +: TRACE_W] = slot[i];
   end

endmodule

// File: tb/tb_picorv32_trace_packer.sv
// Directed bench for picorv32_trace_packer (DEPTH=16, PKT_WORDS=4,
// FLUSH_CYCLES=8). Packets are captured on handshake by a monitor and
// compared field by field against hand-computed values.
module tb_picorv32_trace_packer;
   import picorv32_trace_pkg::*;

   localparam int PW    = 4;
   localparam int PKT_W = HDR_W + TRACE_W * PW;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   always #5 clk = ~clk;

   picorv32_trace_packer_if #(.PKT_WORDS(PW)) bus ();

   picorv32_trace_packer #(
      .DEPTH        (16),
      .PKT_WORDS    (PW),
      .FLUSH_CYCLES (8)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [PKT_W-1:0] pkt_q [$];
   int               vld_cycles = 0;

   // Monitor: sampled mid-cycle, so a valid&&ready seen here is the
   // handshake taken at the following rising edge.
   always @(negedge clk) begin
      if (resetn && bus.out_valid) begin
         vld_cycles <= vld_cycles + 1;
         if (bus.out_ready)
            pkt_q.push_back(bus.out_data);
      end
   end

   task automatic check(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [TRACE_W-1:0] d);
      bus.trace_valid = 1'b1;
      bus.trace_data  = d;
      tick();
      bus.trace_valid = 1'b0;
      bus.trace_data  = '0;
   endtask

   task automatic do_reset();
      bus.trace_valid = 1'b0;
      bus.trace_data  = '0;
      bus.out_ready   = 1'b0;
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      tick();
   endtask

   function automatic logic [PKT_W-1:0] get_pkt(input int idx);
      if (idx < pkt_q.size())
         return pkt_q[idx];
      return '0;
   endfunction

   task automatic wait_pkts(input string tag, input int n, input int budget);
      int waited = 0;
      while ((pkt_q.size() < n) && (waited < budget)) begin
         tick();
         waited++;
      end
      check(tag, pkt_q.size(), n);
   endtask

   // Words present are base, base+1, ...; remaining slots must be zero.
   task automatic check_pkt(input string tag, input int idx, input logic [7:0] hdr,
                            input logic [TRACE_W-1:0] base, input int nwords);
      logic [PKT_W-1:0] p;
      p = get_pkt(idx);
      check({tag, " hdr"}, p[7:0], hdr);
      for (int i = 0; i < PW; i++) begin
         logic [TRACE_W-1:0] e;
         e = (i < nwords) ? base + TRACE_W'(i) : '0;
         check($sformatf("%s w%0d", tag, i), p[HDR_W + TRACE_W*i +: TRACE_W], e);
      end
   endtask

   initial begin
      int base;
      int v0;
      int n;

      bus.trace_valid = 1'b0;
      bus.trace_data  = '0;
      bus.out_ready   = 1'b0;

      // Reset values, while reset is held.
      #2;
      check("rst out_valid", bus.out_valid, 1'b0);
      check("rst out_data", bus.out_data, '0);
      check("rst drop_count", bus.drop_count, 16'h0);
      do_reset();
      check("post-rst out_valid", bus.out_valid, 1'b0);

      // Single full packet.
      bus.out_ready = 1'b1;
      base = pkt_q.size();
      v0   = vld_cycles;
      for (int i = 0; i < 4; i++)
         push(36'h1_0000_0001 + TRACE_W'(i));
      wait_pkts("full pkt count", base + 1, 20);
      repeat (4) tick();
      check_pkt("full pkt", base, 8'h04, 36'h1_0000_0001, 4);
      check("full pkt valid cycles", vld_cycles - v0, 1);

      // Timeout flush: last pop is at the edge after the second push; idle_cnt
      // reaches 8 eight cycles later, SEND is entered one edge after that, so
      // out_valid is first seen at the 11th negedge after the push returns.
      do_reset();
      bus.out_ready = 1'b1;
      base = pkt_q.size();
      push(36'h4_0000_00A0);
      push(36'h4_0000_00A1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && (n < 40));
      check("flush latency", n, 11);
      tick();
      wait_pkts("flush pkt count", base + 1, 10);
      check_pkt("flush pkt", base, 8'h02, 36'h4_0000_00A0, 2);

      // Backpressure and overflow: 4 in the packet, 16 in the FIFO, 20 dropped.
      do_reset();
      base = pkt_q.size();
      for (int i = 0; i < 40; i++)
         push(36'h2_0000_0000 + TRACE_W'(i));
      check("bp out_valid", bus.out_valid, 1'b1);
      check("bp drop_count", bus.drop_count, 16'd20);
      bus.out_ready = 1'b1;
      wait_pkts("bp pkt count", base + 5, 60);
      check_pkt("bp pkt0", base, 8'h84, 36'h2_0000_0000, 4);
      for (int k = 1; k < 5; k++)
         check_pkt($sformatf("bp pkt%0d", k), base + k, 8'h04, 36'h2_0000_0000 + TRACE_W'(4*k), 4);
      repeat (15) tick();
      check("bp no extra pkt", pkt_q.size(), base + 5);

      // Drop coinciding with the handshake: flag survives into the next packet.
      do_reset();
      base = pkt_q.size();
      for (int i = 0; i < 20; i++)
         push(36'h3_0000_0000 + TRACE_W'(i));
      bus.out_ready = 1'b1;
      push(36'h3_0000_0014);
      check("hs drop_count", bus.drop_count, 16'd1);
      wait_pkts("hs pkt count", base + 5, 60);
      check("hs pkt0 cnt", get_pkt(base) & PKT_W'(8'h7F), 4);
      check_pkt("hs pkt1", base + 1, 8'h84, 36'h3_0000_0004, 4);
      check_pkt("hs pkt2", base + 2, 8'h04, 36'h3_0000_0008, 4);

      // Saturation.
      do_reset();
      force dut.drop_cnt = 16'hFFFE;
      #1;
      release dut.drop_cnt;
      check("sat preset", bus.drop_count, 16'hFFFE);
      for (int i = 0; i < 21; i++)
         push(36'h7_0000_0000 + TRACE_W'(i));
      check("sat first drop", bus.drop_count, 16'hFFFF);
      for (int i = 0; i < 4; i++)
         push(36'h7_0000_0100 + TRACE_W'(i));
      check("sat hold", bus.drop_count, 16'hFFFF);
      base = pkt_q.size();
      bus.out_ready = 1'b1;
      wait_pkts("sat drain", base + 5, 60);

      // Reset mid-fill: old words vanish, only the new packet appears.
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++)
         push(36'h5_0000_0000 + TRACE_W'(i));
      resetn = 1'b0;
      #1;
      check("midrst out_valid", bus.out_valid, 1'b0);
      check("midrst drop_count", bus.drop_count, 16'h0);
      tick();
      resetn = 1'b1;
      base = pkt_q.size();
      for (int i = 0; i < 4; i++)
         push(36'h6_0000_0010 + TRACE_W'(i));
      wait_pkts("midrst pkt count", base + 1, 20);
      check_pkt("midrst pkt", base, 8'h04, 36'h6_0000_0010, 4);
      repeat (20) tick();
      check("midrst no extra pkt", pkt_q.size(), base + 1);
      check("midrst final drops", bus.drop_count, 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
